// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection light controller: light codes, timing-table
// selectors and the phase scheduler state encoding.
package traffic_pkg;

  typedef enum logic [1:0] {
    LightRed    = 2'b00,
    LightYellow = 2'b01,
    LightGreen  = 2'b10,
    LightOff    = 2'b11
  } light_e;

  typedef enum logic [1:0] {
    TimingA = 2'b00,
    TimingB = 2'b01,
    TimingC = 2'b10,
    TimingD = 2'b11
  } timing_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StLoad  = 2'b01,
    StCount = 2'b10,
    StDone  = 2'b11
  } sched_state_e;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a debounce counter; the output only toggles after
// the synchronised input has disagreed with it for DEBOUNCE_TICKS consecutive cycles.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_TICKS = 500
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned CntW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dout_q, dout_d;

  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (sync_q[1] == dout_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DEBOUNCE_TICKS - 1)) begin
      // This cycle is the DEBOUNCE_TICKS-th consecutive disagreement.
      dout_d = ~dout_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/phase_scheduler.sv
// Phase timer for the light state machine: counts secondsToCount seconds, pulses tick each
// second and finished at phase end, and debounces the three vehicle sensors.
module phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 10000,
  parameter int unsigned DEBOUNCE_TICKS = 500,
  parameter int unsigned SEC_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             hold,
  input  logic [SEC_W-1:0] secondsToCount,
  input  logic             SNN_raw,
  input  logic             SNS_raw,
  input  logic             STH_raw,
  output logic             SNN,
  output logic             SNS,
  output logic             STH,
  output logic             finished,
  output logic             tick,
  output logic [SEC_W-1:0] remaining,
  output logic             busy
);

  localparam int unsigned PrescW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  sched_state_e      state_q, state_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [SEC_W-1:0]  sec_rem_q, sec_rem_d;
  logic              presc_wrap;

  assign presc_wrap = (presc_q == PrescW'(CLK_HZ - 1));

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    sec_rem_d = sec_rem_q;
    tick      = 1'b0;
    if (!enable) begin
      state_d   = StIdle;
      presc_d   = '0;
      sec_rem_d = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StLoad;
        StLoad: begin
          state_d   = StCount;
          presc_d   = '0;
          // A zero-length request still runs for one second so finished always fires.
          sec_rem_d = (secondsToCount == '0) ? SEC_W'(1) : secondsToCount;
        end
        StCount: begin
          if (!hold) begin
            if (presc_wrap) begin
              presc_d = '0;
              tick    = 1'b1;
              if (sec_rem_q == SEC_W'(1)) begin
                state_d = StDone;
              end else begin
                sec_rem_d = sec_rem_q - SEC_W'(1);
              end
            end else begin
              presc_d = presc_q + PrescW'(1);
            end
          end
        end
        StDone:  state_d = StLoad;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      sec_rem_q <= '0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      sec_rem_q <= sec_rem_d;
    end
  end

  assign finished  = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign remaining = (state_q == StCount || state_q == StDone) ? sec_rem_q : '0;

  sensor_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_snn (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (SNN_raw),
    .dout   (SNN)
  );

  sensor_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_sns (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (SNS_raw),
    .dout   (SNS)
  );

  sensor_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_sth (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (STH_raw),
    .dout   (STH)
  );

endmodule

// File: tb/tb_phase_scheduler.sv
// Scoreboard bench for phase_scheduler: expected tick/finished/remaining/sensor events are
// queued as stimulus is applied and compared by a negedge monitor when they occur.
module tb_phase_scheduler;

  localparam int unsigned ClkHz = 10;
  localparam int unsigned DebTicks = 4;
  localparam int unsigned SecW = 16;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            enable = 1'b0;
  logic            hold = 1'b0;
  logic [SecW-1:0] secondsToCount = '0;
  logic            SNN_raw = 1'b0, SNS_raw = 1'b0, STH_raw = 1'b0;
  logic            SNN, SNS, STH;
  logic            finished, tick, busy;
  logic [SecW-1:0] remaining;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  int  tick_q[$];
  int  fin_q[$];
  ev_t rem_q[$];
  ev_t sns_q[$];

  phase_scheduler #(
    .CLK_HZ        (ClkHz),
    .DEBOUNCE_TICKS(DebTicks),
    .SEC_W         (SecW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .hold          (hold),
    .secondsToCount(secondsToCount),
    .SNN_raw       (SNN_raw),
    .SNS_raw       (SNS_raw),
    .STH_raw       (STH_raw),
    .SNN           (SNN),
    .SNS           (SNS),
    .STH           (STH),
    .finished      (finished),
    .tick          (tick),
    .remaining     (remaining),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) wait_cycles(1);
  endtask

  // Phase whose LOAD cycle follows edge e; h = hold cycles inside COUNT.
  task automatic expect_phase(input int e, input int n, input int h);
    ev_t ev;
    ev.cyc = e; ev.val = 0;
    rem_q.push_back(ev);
    for (int k = 1; k <= n; k++) begin
      tick_q.push_back(e + k * ClkHz + h);
      ev.cyc = e + k * ClkHz + h; ev.val = n - k + 1;
      rem_q.push_back(ev);
    end
    fin_q.push_back(e + n * ClkHz + h + 1);
    ev.cyc = e + n * ClkHz + h + 1; ev.val = 1;
    rem_q.push_back(ev);
  endtask

  task automatic expect_sensors(input int c, input int vec);
    ev_t ev;
    ev.cyc = c; ev.val = vec;
    sns_q.push_back(ev);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  int prev_sns = 0;
  always @(negedge clk) begin
    int  exp_c;
    ev_t ev;
    int  vec;
    if (tick) begin
      exp_c = (tick_q.size() > 0) ? tick_q.pop_front() : -1;
      check_eq("tick_cycle", cyc, exp_c);
    end
    if (finished) begin
      exp_c = (fin_q.size() > 0) ? fin_q.pop_front() : -1;
      check_eq("finished_cycle", cyc, exp_c);
    end
    if (rem_q.size() > 0 && rem_q[0].cyc == cyc) begin
      ev = rem_q.pop_front();
      check_eq("remaining", int'(remaining), ev.val);
    end
    vec = int'({SNN, SNS, STH});
    if (vec != prev_sns) begin
      if (sns_q.size() > 0) ev = sns_q.pop_front();
      else begin ev.cyc = -1; ev.val = -1; end
      check_eq("sensor_cycle", cyc, ev.cyc);
      check_eq("sensor_value", vec, ev.val);
      prev_sns = vec;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c, e;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_remaining", int'(remaining), 0);
    check_eq("rst_finished", int'(finished), 0);
    check_eq("rst_sensors", int'({SNN, SNS, STH}), 0);
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(2);

    // 3-second phase, then a 1-second phase; hold in DONE/LOAD must be ignored.
    c = cyc; secondsToCount = 16'd3; enable = 1'b1; e = c + 1;
    expect_phase(e, 3, 0);
    expect_phase(e + 32, 1, 0);
    wait_until(e + 5);
    check_eq("busy_count", int'(busy), 1);
    wait_until(e + 31);
    secondsToCount = 16'd1; hold = 1'b1;
    wait_until(e + 33);
    hold = 1'b0;
    wait_until(e + 43);
    enable = 1'b0;
    wait_until(e + 44);
    check_eq("idle_busy", int'(busy), 0);
    check_eq("idle_remaining", int'(remaining), 0);
    wait_cycles(2);

    // Zero seconds behaves as one second.
    c = cyc; secondsToCount = 16'd0; enable = 1'b1; e = c + 1;
    expect_phase(e, 1, 0);
    wait_until(e + 11);
    enable = 1'b0;
    wait_cycles(2);

    // 7-cycle hold inside COUNT stretches the phase by 7 cycles.
    c = cyc; secondsToCount = 16'd2; enable = 1'b1; e = c + 1;
    expect_phase(e, 2, 7);
    wait_until(e + 3);
    hold = 1'b1;
    wait_until(e + 10);
    hold = 1'b0;
    wait_until(e + 28);
    enable = 1'b0;
    wait_cycles(2);

    // Enable dropped mid-COUNT together with hold: enable wins, then a full re-run.
    c = cyc; secondsToCount = 16'd2; enable = 1'b1; e = c + 1;
    begin
      ev_t ev;
      ev.cyc = e; ev.val = 0; rem_q.push_back(ev);
      tick_q.push_back(e + 10);
      ev.cyc = e + 10; ev.val = 2; rem_q.push_back(ev);
      ev.cyc = e + 15; ev.val = 0; rem_q.push_back(ev);
    end
    wait_until(e + 14);
    enable = 1'b0; hold = 1'b1;
    wait_until(e + 15);
    check_eq("drop_busy", int'(busy), 0);
    hold = 1'b0;
    wait_cycles(3);
    c = cyc; enable = 1'b1; e = c + 1;
    expect_phase(e, 2, 0);
    wait_until(e + 21);
    enable = 1'b0;
    wait_cycles(2);

    // Asynchronous reset mid-COUNT, released between edges with enable held high.
    c = cyc; secondsToCount = 16'd3; enable = 1'b1; e = c + 1;
    begin
      ev_t ev;
      ev.cyc = e; ev.val = 0; rem_q.push_back(ev);
      tick_q.push_back(e + 10);
      ev.cyc = e + 10; ev.val = 3; rem_q.push_back(ev);
    end
    wait_until(e + 12);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_busy", int'(busy), 0);
    check_eq("arst_remaining", int'(remaining), 0);
    check_eq("arst_tick", int'(tick), 0);
    check_eq("arst_finished", int'(finished), 0);
    #2 reset_n = 1'b1;
    e = cyc + 1;
    expect_phase(e, 3, 0);
    wait_until(e + 31);
    enable = 1'b0;
    wait_cycles(2);

    // Sensors: 3-cycle glitch rejected, 10-cycle pulse passes, exact 4-cycle pulse passes.
    c = cyc; SNN_raw = 1'b1;
    wait_cycles(3);
    SNN_raw = 1'b0;
    wait_cycles(10);
    c = cyc; SNN_raw = 1'b1; STH_raw = 1'b1;
    expect_sensors(c + 6, 3'b101);
    expect_sensors(c + 16, 3'b001);
    expect_sensors(c + 21, 3'b000);
    wait_until(c + 10);
    SNN_raw = 1'b0;
    wait_until(c + 15);
    STH_raw = 1'b0;
    wait_until(c + 30);
    c = cyc; SNS_raw = 1'b1;
    expect_sensors(c + 6, 3'b010);
    expect_sensors(c + 10, 3'b000);
    wait_cycles(4);
    SNS_raw = 1'b0;
    wait_cycles(12);

    check_eq("tick_q_left", tick_q.size(), 0);
    check_eq("fin_q_left", fin_q.size(), 0);
    check_eq("rem_q_left", rem_q.size(), 0);
    check_eq("sns_q_left", sns_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
